// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - masked, directional select scan for the 4:1 logic mux
// Settles each enabled channel, samples mux_out once, and packs the bits into data.
module mux_scan_ctrl #(
  parameter int SEL_W       = 2,
  parameter int HOLD_CYCLES = 1,
  localparam int N_CH       = 2 ** SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_CH-1:0]   mask,
  input  logic              dir,
  input  logic              mux_out,
  output logic [SEL_W-1:0]  a,
  output logic              busy,
  output logic              done,
  output logic [N_CH-1:0]   data,
  output logic [SEL_W:0]    ch_cnt
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t           state_q;
  logic [SEL_W-1:0] a_q;
  logic             busy_q;
  logic             done_q;
  logic [N_CH-1:0]  data_q;
  logic [SEL_W:0]   ch_cnt_q;
  logic [3:0]       hold_q;
  logic [N_CH-1:0]  mask_q;
  logic             dir_q;
  logic [SEL_W:0]   first_d;
  logic [SEL_W:0]   next_d;

  // Returns {found, index} of the first set bit strictly beyond `from` in direction d.
  function automatic logic [SEL_W:0] find_ch(input logic [N_CH-1:0] m, input int from,
                                             input logic d);
    logic [SEL_W:0]   r;
    logic [SEL_W-1:0] idx;
    int               j;
    r = '0;
    for (int i = 0; i < N_CH; i++) begin
      j   = d ? (N_CH - 1 - i) : i;
      idx = SEL_W'(j);
      if (!r[SEL_W] && m[idx] && (d ? (j < from) : (j > from))) begin
        r = {1'b1, idx};
      end
    end
    return r;
  endfunction

  always_comb begin
    first_d = find_ch(mask, dir ? N_CH : -1, dir);
    next_d  = find_ch(mask_q, int'(a_q), dir_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
      ch_cnt_q <= '0;
      hold_q   <= '0;
      mask_q   <= '0;
      dir_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mask_q   <= mask;
            dir_q    <= dir;
            data_q   <= '0;
            ch_cnt_q <= '0;
            hold_q   <= '0;
            if (first_d[SEL_W]) begin
              a_q     <= first_d[SEL_W-1:0];
              busy_q  <= 1'b1;
              state_q <= SETTLE;
            end else begin
              state_q <= DONE;
            end
          end
        end
        SETTLE: begin
          hold_q <= hold_q + 4'd1;
          if (hold_q == 4'(HOLD_CYCLES - 1)) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          data_q[a_q] <= mux_out;
          ch_cnt_q    <= ch_cnt_q + 1'b1;
          if (next_d[SEL_W]) begin
            a_q     <= next_d[SEL_W-1:0];
            hold_q  <= '0;
            state_q <= SETTLE;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          // An empty mask arrives here with done low, so it waits one cycle to pulse done.
          if (done_q) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign a      = a_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign data   = data_q;
  assign ch_cnt = ch_cnt_q;

endmodule
